// File: rtl/adc_multi_snapshot_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_multi_snapshot_if
// Bundles the signals that cross between the snapshot block and its neighbours:
//   - the lockstep AXI-stream sink from the RFDC tile (s_tdata/s_tvalid/s_tready)
//   - the registered BRAM read-back port used by the AXI-lite bridge
//     (rd_en/rd_ch/rd_addr -> rd_data/rd_valid)
// Modports:
//   master : the side that produces stream data and issues reads (tile + bridge)
//   slave  : the snapshot capture block itself
// -----------------------------------------------------------------------------
interface adc_multi_snapshot_if #(
    parameter int N_CH       = 2,
    parameter int DIN_WIDTH  = 128,
    parameter int ADDR_WIDTH = 9
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*DIN_WIDTH-1:0] s_tdata;
    logic [N_CH-1:0]           s_tvalid;
    logic [N_CH-1:0]           s_tready;

    logic                      rd_en;
    logic [CH_W-1:0]           rd_ch;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [DIN_WIDTH-1:0]      rd_data;
    logic                      rd_valid;

    modport master (
        output s_tdata, s_tvalid, rd_en, rd_ch, rd_addr,
        input  s_tready, rd_data, rd_valid
    );

    modport slave (
        input  s_tdata, s_tvalid, rd_en, rd_ch, rd_addr,
        output s_tready, rd_data, rd_valid
    );
endinterface

// File: rtl/adc_multi_snapshot.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_multi_snapshot
// N-channel snapshot capture for RFDC ADC stream outputs. A capture is armed
// with a one-cycle pulse, waits for the selected trigger, then stores the next
// 'len' beats on which every channel is valid into one BRAM per channel. The
// buffers are read back through a one-cycle-latency registered read port.
//
// Ports:
//   clk          ADC stream clock, everything on the rising edge
//   rst          synchronous active-high reset
//   bus          slave side of adc_multi_snapshot_if (stream sink + read port)
//   arm          one-cycle pulse, starts a capture from IDLE or DONE
//   trig_mode    0 immediate, 1/3 software pulse, 2 external rising edge
//   trig_sw      software trigger pulse
//   trig_ext     external trigger level (already synchronous to clk)
//   capture_len  beats to capture, latched on arm (0 or > depth means depth)
//   busy         high while ARMED or CAPTURE
//   done         high while DONE
//   wr_count     beats written in the current capture
//   skew_err     sticky: channels disagreed on tvalid during CAPTURE
// -----------------------------------------------------------------------------
module adc_multi_snapshot #(
    parameter int N_CH       = 2,
    parameter int DIN_WIDTH  = 128,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_multi_snapshot_if.slave   bus,
    input  logic                  arm,
    input  logic [1:0]            trig_mode,
    input  logic                  trig_sw,
    input  logic                  trig_ext,
    input  logic [ADDR_WIDTH:0]   capture_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  skew_err
);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DEPTH_N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH:0]   len_reg, len_next;
    logic [ADDR_WIDTH:0]   wr_count_reg, wr_count_next;
    logic                  skew_err_reg, skew_err_next;
    logic                  trig_prev_reg;
    logic [N_CH-1:0]       ready_reg;

    logic                  all_valid;
    logic                  any_valid;
    logic                  trig_edge;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH:0]   len_sel;

    assign all_valid = &bus.s_tvalid;
    assign any_valid = |bus.s_tvalid;
    assign trig_edge = trig_ext & ~trig_prev_reg;
    assign wr_addr   = wr_count_reg[ADDR_WIDTH-1:0];

    // Zero and oversize lengths both mean "fill the whole buffer".
    assign len_sel = ((capture_len == '0) || (capture_len > DEPTH)) ? DEPTH : capture_len;

    // ------------------------------------------------------------------
    // Control state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            len_reg      <= DEPTH;
            wr_count_reg <= '0;
            skew_err_reg <= 1'b0;
            ready_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            wr_count_reg <= wr_count_next;
            skew_err_reg <= skew_err_next;
            ready_reg    <= '1;
        end
    end

    // The edge detector follows trig_ext in every state (including reset) so
    // that a level already high when the capture is armed never looks like an
    // edge.
    always_ff @(posedge clk) begin
        trig_prev_reg <= trig_ext;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        wr_count_next = wr_count_reg;
        skew_err_next = skew_err_reg;
        wr_en         = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_next    = ST_ARMED;
                    len_next      = len_sel;
                    wr_count_next = '0;
                    skew_err_next = 1'b0;
                end
            end

            ST_ARMED: begin
                // trig_mode is looked at every cycle while armed, so software
                // may change it after arming.
                case (trig_mode)
                    2'd0:    state_next = ST_CAPTURE;
                    2'd2:    if (trig_edge) state_next = ST_CAPTURE;
                    default: if (trig_sw)   state_next = ST_CAPTURE;
                endcase
            end

            ST_CAPTURE: begin
                // Only beats where every channel is valid are stored, so the
                // buffers stay aligned; a partial beat is dropped and flagged.
                if (all_valid) begin
                    wr_en         = 1'b1;
                    wr_count_next = wr_count_reg + 1'b1;
                    if (wr_count_reg + 1'b1 == len_reg) begin
                        state_next = ST_DONE;
                    end
                end else if (any_valid) begin
                    skew_err_next = 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel buffers. Read-first behaviour: a read of the address being
    // written in the same cycle returns the previous contents.
    // ------------------------------------------------------------------
    logic [N_CH*DIN_WIDTH-1:0] rd_word_flat;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DIN_WIDTH-1:0] mem [DEPTH_N];
            logic [DIN_WIDTH-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_addr] <= bus.s_tdata[gi*DIN_WIDTH +: DIN_WIDTH];
                end
                if (bus.rd_en) begin
                    rd_q <= mem[bus.rd_addr];
                end
            end

            assign rd_word_flat[gi*DIN_WIDTH +: DIN_WIDTH] = rd_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read output select. The channel select is captured alongside the BRAM
    // read so rd_data holds its last value while rd_en is low. rd_zero_reg
    // forces zero after reset and for reads of a non-existent channel, which
    // keeps the BRAM output register itself free of reset logic.
    // ------------------------------------------------------------------
    logic            rd_valid_reg;
    logic [CH_W-1:0] rd_sel_reg;
    logic            rd_zero_reg;
    logic            rd_oob;

    assign rd_oob = (int'(bus.rd_ch) >= N_CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_sel_reg   <= '0;
            rd_zero_reg  <= 1'b1;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel_reg  <= bus.rd_ch;
                rd_zero_reg <= rd_oob;
            end
        end
    end

    assign bus.rd_data  = rd_zero_reg ? '0 : rd_word_flat[rd_sel_reg*DIN_WIDTH +: DIN_WIDTH];
    assign bus.rd_valid = rd_valid_reg;
    assign bus.s_tready = ready_reg;

    assign busy     = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
    assign done     = (state_reg == ST_DONE);
    assign wr_count = wr_count_reg;
    assign skew_err = skew_err_reg;

endmodule

// File: tb/tb_adc_multi_snapshot.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_adc_multi_snapshot
// Table of capture scenarios (length, trigger mode, tvalid pattern, skew
// injection) applied in a loop, plus hand-written sequences for the external
// trigger level/edge case and reset / re-arm behaviour. Every stored beat is
// recorded from the stimulus; read-backs push their expected word into a
// queue and a monitor pops and compares on each rd_valid.
// -----------------------------------------------------------------------------
module tb_adc_multi_snapshot;
    localparam int N_CH       = 2;
    localparam int DIN_WIDTH  = 128;
    localparam int ADDR_WIDTH = 9;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic                clk;
    logic                rst;
    logic                arm;
    logic [1:0]          trig_mode;
    logic                trig_sw;
    logic                trig_ext;
    logic [ADDR_WIDTH:0] capture_len;
    logic                busy;
    logic                done;
    logic [ADDR_WIDTH:0] wr_count;
    logic                skew_err;

    adc_multi_snapshot_if #(
        .N_CH(N_CH), .DIN_WIDTH(DIN_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) sif ();

    adc_multi_snapshot #(
        .N_CH(N_CH), .DIN_WIDTH(DIN_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif),
        .arm(arm),
        .trig_mode(trig_mode),
        .trig_sw(trig_sw),
        .trig_ext(trig_ext),
        .capture_len(capture_len),
        .busy(busy),
        .done(done),
        .wr_count(wr_count),
        .skew_err(skew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int seq_cnt = 0;
    int cyc_cnt = 0;
    bit have_prev = 0;

    logic [DIN_WIDTH-1:0] cur_w0, cur_w1;
    logic [DIN_WIDTH-1:0] exp_data [N_CH][DEPTH];
    logic [DIN_WIDTH-1:0] exp_q [$];
    logic [DIN_WIDTH-1:0] last_rd;

    typedef struct {
        int len_in;
        int mode;
        bit toggle;
        int skew_at;
        int exp_len;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    function automatic logic [DIN_WIDTH-1:0] mk_word(input int ch, input int seq);
        return {32'(seq), 32'(ch) ^ 32'hC0DE_0000, ~32'(seq), 32'(seq * 7 + ch)};
    endfunction

    task automatic drive_beat(input logic [1:0] v);
        seq_cnt++;
        cur_w0 = mk_word(0, seq_cnt);
        cur_w1 = mk_word(1, seq_cnt);
        sif.s_tdata  = {cur_w1, cur_w0};
        sif.s_tvalid = v;
    endtask

    // Read monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (sif.rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected_valid", sif.rd_valid, 1'b0);
            end else begin
                chk("rd_data", sif.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic readback(input int n);
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int a = 0; a < n; a++) begin
                sif.rd_en   = 1'b1;
                sif.rd_ch   = 1'(ch);
                sif.rd_addr = ADDR_WIDTH'(a);
                exp_q.push_back(exp_data[ch][a]);
                last_rd = exp_data[ch][a];
                cyc();
            end
        end
        sif.rd_en = 1'b0;
        cyc();
        cyc();
        chk("rd_queue_drained", exp_q.size(), 0);
        chk("rd_data_hold", sif.rd_data, last_rd);
    endtask

    // Drive beats after the trigger cycle until exp_len beats have been stored.
    task automatic capture_beats(input int exp_len, input bit toggle, input int skew_at);
        int   n = 0;
        int   k = 0;
        int   budget = 4 * exp_len + 20;
        bit   skewed = 0;
        logic v;
        while (n < exp_len && budget > 0) begin
            budget--;
            if (skew_at >= 0 && n == skew_at && !skewed) begin
                skewed = 1;
                repeat (3) begin
                    drive_beat(2'b01);
                    cyc();
                end
                chk("skew_no_write", wr_count, n);
                chk("skew_flag_set", skew_err, 1'b1);
            end
            v = toggle ? k[0] : 1'b1;
            k++;
            drive_beat({v, v});
            if (v) begin
                if (n == 0 && have_prev) begin
                    // Same-cycle read of the address being written: old data.
                    sif.rd_en   = 1'b1;
                    sif.rd_ch   = 1'b0;
                    sif.rd_addr = '0;
                    exp_q.push_back(exp_data[0][0]);
                end
                if (n == exp_len - 1) begin
                    chk("done_before_last", done, 1'b0);
                    chk("busy_before_last", busy, 1'b1);
                end
                exp_data[0][n] = cur_w0;
                exp_data[1][n] = cur_w1;
                n++;
            end
            cyc();
            sif.rd_en = 1'b0;
        end
        chk("capture_in_budget", n, exp_len);
    endtask

    task automatic post_checks(input int exp_len, input bit exp_skew);
        chk("done_after_capture", done, 1'b1);
        chk("busy_after_capture", busy, 1'b0);
        chk("wr_count_final", wr_count, exp_len);
        chk("skew_err_final", skew_err, exp_skew);
        drive_beat(2'b11);
        cyc();
        chk("wr_count_frozen_in_done", wr_count, exp_len);
        sif.s_tvalid = 2'b00;
        readback(exp_len);
        have_prev = 1;
    endtask

    task automatic run_capture(input vec_t tv);
        int arm_cyc;
        if (tv.mode == 1 || tv.mode == 3) begin
            // Software trigger outside ARMED must not be remembered.
            trig_sw = 1'b1;
            cyc();
            trig_sw = 1'b0;
        end
        if (tv.mode == 2) begin
            trig_ext = 1'b0;
            cyc();
        end
        capture_len = (ADDR_WIDTH + 1)'(tv.len_in);
        trig_mode   = 2'(tv.mode);
        arm         = 1'b1;
        drive_beat(2'b11);
        cyc();
        arm_cyc = cyc_cnt;
        arm     = 1'b0;
        chk("armed_busy", busy, 1'b1);
        chk("armed_done_clear", done, 1'b0);
        chk("armed_wr_count", wr_count, 0);

        if (tv.mode == 1 || tv.mode == 3) begin
            repeat (2) begin
                drive_beat(2'b11);
                cyc();
            end
            chk("sw_wait_no_write", wr_count, 0);
            chk("sw_wait_busy", busy, 1'b1);
            trig_sw = 1'b1;
            drive_beat(2'b11);
            cyc();
            trig_sw = 1'b0;
        end else if (tv.mode == 2) begin
            trig_ext = 1'b1;
            drive_beat(2'b11);
            cyc();
        end else begin
            drive_beat(2'b11);   // trigger cycle beat, not stored
            cyc();
        end
        chk("trigger_beat_skipped", wr_count, 0);

        capture_beats(tv.exp_len, tv.toggle, tv.skew_at);
        if (tv.mode == 0 && !tv.toggle && tv.skew_at < 0) begin
            // Counting the arm cycle itself this is len+2 cycles.
            chk("arm_to_done_edges", cyc_cnt - arm_cyc, tv.exp_len + 1);
        end
        post_checks(tv.exp_len, tv.skew_at >= 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{len_in: 16,        mode: 0, toggle: 0, skew_at: -1, exp_len: 16};
        vecs[1] = '{len_in: 0,         mode: 0, toggle: 0, skew_at: -1, exp_len: DEPTH};
        vecs[2] = '{len_in: DEPTH + 5, mode: 0, toggle: 0, skew_at: -1, exp_len: DEPTH};
        vecs[3] = '{len_in: 24,        mode: 0, toggle: 1, skew_at: -1, exp_len: 24};
        vecs[4] = '{len_in: 8,         mode: 1, toggle: 0, skew_at: -1, exp_len: 8};
        vecs[5] = '{len_in: 12,        mode: 2, toggle: 1, skew_at: -1, exp_len: 12};
        vecs[6] = '{len_in: 10,        mode: 3, toggle: 0, skew_at: -1, exp_len: 10};
        vecs[7] = '{len_in: 8,         mode: 0, toggle: 0, skew_at: 3,  exp_len: 8};
        vecs[8] = '{len_in: 1,         mode: 0, toggle: 0, skew_at: -1, exp_len: 1};

        rst = 1'b1;
        arm = 1'b0;
        trig_mode = 2'd0;
        trig_sw = 1'b0;
        trig_ext = 1'b0;
        capture_len = '0;
        sif.s_tdata = '0;
        sif.s_tvalid = '0;
        sif.rd_en = 1'b0;
        sif.rd_ch = '0;
        sif.rd_addr = '0;
        last_rd = '0;
        repeat (3) cyc();

        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_wr_count", wr_count, 0);
        chk("reset_skew_err", skew_err, 1'b0);
        chk("reset_rd_valid", sif.rd_valid, 1'b0);
        chk("reset_rd_data", sif.rd_data, 0);
        chk("reset_tready", sif.s_tready, 2'b00);
        rst = 1'b0;
        cyc();
        chk("tready_after_reset", sif.s_tready, 2'b11);

        // Table-driven captures; each arm after the first comes from DONE.
        for (int i = 0; i < 9; i++) begin
            run_capture(vecs[i]);
        end

        // External trigger already high at arm: no edge, stays armed.
        trig_ext  = 1'b1;
        trig_mode = 2'd2;
        cyc();
        capture_len = 4;
        arm = 1'b1;
        drive_beat(2'b11);
        cyc();
        arm = 1'b0;
        repeat (4) begin
            drive_beat(2'b11);
            cyc();
        end
        chk("ext_high_still_armed", busy, 1'b1);
        chk("ext_high_no_write", wr_count, 0);
        trig_ext = 1'b0;
        drive_beat(2'b11);
        cyc();
        chk("ext_low_no_write", wr_count, 0);
        trig_ext = 1'b1;
        drive_beat(2'b11);
        cyc();
        chk("ext_edge_beat_skipped", wr_count, 0);
        capture_beats(4, 1'b0, -1);
        post_checks(4, 1'b0);

        // Reset mid-capture, with an ignored arm along the way.
        have_prev = 0;
        trig_mode = 2'd0;
        capture_len = 20;
        arm = 1'b1;
        drive_beat(2'b11);
        cyc();
        arm = 1'b0;
        drive_beat(2'b11);
        cyc();
        repeat (5) begin
            drive_beat(2'b11);
            cyc();
        end
        chk("partial_wr_count", wr_count, 5);
        arm = 1'b1;
        drive_beat(2'b11);
        cyc();
        arm = 1'b0;
        chk("arm_in_capture_ignored", wr_count, 6);
        chk("arm_in_capture_busy", busy, 1'b1);
        drive_beat(2'b11);
        cyc();
        chk("wr_count_seven", wr_count, 7);
        rst = 1'b1;
        drive_beat(2'b11);
        cyc();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_wr_count", wr_count, 0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_tready", sif.s_tready, 2'b00);
        rst = 1'b0;
        drive_beat(2'b11);
        cyc();
        chk("postrst_tready", sif.s_tready, 2'b11);
        drive_beat(2'b11);
        cyc();
        chk("postrst_idle_no_write", wr_count, 0);
        chk("postrst_idle_busy", busy, 1'b0);

        run_capture('{len_in: 6, mode: 0, toggle: 0, skew_at: -1, exp_len: 6});
        run_capture('{len_in: 5, mode: 1, toggle: 1, skew_at: -1, exp_len: 5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
